// File: rtl/ntt_bram_stream_io_if.sv
// rtl/ntt_bram_stream_io_if.sv - stream and BRAM signal bundle for ntt_bram_stream_io
interface ntt_bram_stream_io_if #(
    parameter int DW = 128,
    parameter int SW = 32,
    parameter int AW = 13
);
    logic          ss_tvalid;
    logic [SW-1:0] ss_tdata;
    logic          ss_tlast;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [SW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;
    logic          bram_EN;
    logic [3:0]    bram_WE;
    logic [AW-1:0] bram_A;
    logic [DW-1:0] bram_Di;
    logic [DW-1:0] bram_Do;

    modport master (
        input  ss_tvalid, ss_tdata, ss_tlast, sm_tready, bram_Do,
        output ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        output bram_EN, bram_WE, bram_A, bram_Di
    );

    modport slave (
        output ss_tvalid, ss_tdata, ss_tlast, sm_tready, bram_Do,
        input  ss_tready, sm_tvalid, sm_tdata, sm_tlast,
        input  bram_EN, bram_WE, bram_A, bram_Di
    );
endinterface

// File: rtl/ntt_bram_stream_io.sv
// rtl/ntt_bram_stream_io.sv - 32-bit stream <-> 128-bit NTT coefficient BRAM adapter
// Optional unload prefetch buffer: define NTT_UNLOAD_PREFETCH_EN.
module ntt_bram_stream_io #(
    parameter int DW = 128,
    parameter int WL = 128,
    parameter int SW = 32,
    parameter int AW = 13
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start_load,
    input  logic       start_unload,
    input  logic [7:0] cfg_lines,
    output logic       busy,
    output logic       done,
    output logic       err_len,
    ntt_bram_stream_io_if.master io
);
    localparam int NS = DW / SW;
    localparam int KW = $clog2(NS);
    localparam int LW = $clog2(WL);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LWR, S_UREAD, S_UCAP, S_UEMIT, S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] line, last_line;
    logic [KW-1:0] k;
    logic [DW-1:0] pack, pack_ins, shreg;
    logic          tlast_seen, err_q;
    logic          bram_en_q;
    logic [3:0]    bram_we_q;
    logic [AW-1:0] bram_a_q;
    logic [DW-1:0] bram_di_q;
    logic          ss_hs, sm_hs, slot_last, at_last_line, last_word;
    logic [LW:0]   n_cfg;
`ifdef NTT_UNLOAD_PREFETCH_EN
    logic [DW-1:0] nbuf;
    logic          rd_pend, rd_cap;
`endif

    function automatic logic [AW-1:0] line_addr(input logic [LW-1:0] l);
        return AW'(l) << 2;
    endfunction

    assign slot_last    = (k == KW'(NS - 1));
    assign at_last_line = (line == last_line);
    assign last_word    = at_last_line && slot_last;
    assign ss_hs        = (state == S_LOAD) && io.ss_tvalid;
    assign sm_hs        = (state == S_UEMIT) && io.sm_tready;
    assign n_cfg        = (cfg_lines == 8'd0 || 32'(cfg_lines) > WL) ? (LW+1)'(WL)
                                                                     : (LW+1)'(cfg_lines);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_load)        state_nxt = S_LOAD;
                     else if (start_unload) state_nxt = S_UREAD;
            S_LOAD:  if (ss_hs && (slot_last || io.ss_tlast)) state_nxt = S_LWR;
            S_LWR:   state_nxt = (at_last_line || tlast_seen) ? S_FIN : S_LOAD;
            S_UREAD: state_nxt = S_UCAP;
            S_UCAP:  state_nxt = S_UEMIT;
            S_UEMIT: if (sm_hs && slot_last) begin
                         if (at_last_line) state_nxt = S_FIN;
`ifdef NTT_UNLOAD_PREFETCH_EN
                         else              state_nxt = S_UEMIT;
`else
                         else              state_nxt = S_UREAD;
`endif
                     end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_FIN);
        err_len      = err_q;
        io.ss_tready = (state == S_LOAD);
        io.sm_tvalid = (state == S_UEMIT);
        io.sm_tdata  = shreg[SW-1:0];
        io.sm_tlast  = (state == S_UEMIT) && last_word;
        io.bram_EN   = bram_en_q;
        io.bram_WE   = bram_we_q;
        io.bram_A    = bram_a_q;
        io.bram_Di   = bram_di_q;
        pack_ins     = pack;
        pack_ins[int'(k)*SW +: SW] = io.ss_tdata;
    end

    // BRAM controls are registered: they are set on the edge that enters LWR/UREAD.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            line       <= '0;
            last_line  <= '0;
            k          <= '0;
            pack       <= '0;
            shreg      <= '0;
            tlast_seen <= 1'b0;
            err_q      <= 1'b0;
            bram_en_q  <= 1'b0;
            bram_we_q  <= '0;
            bram_a_q   <= '0;
            bram_di_q  <= '0;
`ifdef NTT_UNLOAD_PREFETCH_EN
            nbuf       <= '0;
            rd_pend    <= 1'b0;
            rd_cap     <= 1'b0;
`endif
        end else begin
            bram_en_q <= 1'b0;
            bram_we_q <= '0;
`ifdef NTT_UNLOAD_PREFETCH_EN
            rd_pend   <= 1'b0;
            rd_cap    <= rd_pend;
            if (rd_cap) nbuf <= io.bram_Do;
`endif
            case (state)
                S_IDLE: if (start_load || start_unload) begin
                    line       <= '0;
                    k          <= '0;
                    pack       <= '0;
                    tlast_seen <= 1'b0;
                    err_q      <= 1'b0;
                    last_line  <= LW'(n_cfg - (LW+1)'(1));
                    if (!start_load) begin
                        bram_en_q <= 1'b1;
                        bram_a_q  <= '0;
                    end
                end
                S_LOAD: if (ss_hs) begin
                    pack <= pack_ins;
                    k    <= k + KW'(1);
                    if (io.ss_tlast) tlast_seen <= 1'b1;
                    if (io.ss_tlast != last_word) err_q <= 1'b1;
                    if (slot_last || io.ss_tlast) begin
                        k         <= '0;
                        bram_en_q <= 1'b1;
                        bram_we_q <= 4'hF;
                        bram_a_q  <= line_addr(line);
                        bram_di_q <= pack_ins;
                    end
                end
                S_LWR: begin
                    pack <= '0;
                    if (!(at_last_line || tlast_seen)) line <= line + LW'(1);
                end
                S_UCAP: shreg <= io.bram_Do;
                S_UEMIT: if (sm_hs) begin
                    shreg <= shreg >> SW;
                    k     <= k + KW'(1);
`ifdef NTT_UNLOAD_PREFETCH_EN
                    // Fetch the next line while slot 1 is on the bus; it lands in nbuf before slot 3 retires.
                    if (k == '0 && !at_last_line) begin
                        bram_en_q <= 1'b1;
                        bram_a_q  <= line_addr(line + LW'(1));
                        rd_pend   <= 1'b1;
                    end
                    if (slot_last && !at_last_line) begin
                        line  <= line + LW'(1);
                        shreg <= nbuf;
                    end
`else
                    if (slot_last && !at_last_line) begin
                        line      <= line + LW'(1);
                        bram_en_q <= 1'b1;
                        bram_a_q  <= line_addr(line + LW'(1));
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_bram_stream_io.sv
// tb/tb_ntt_bram_stream_io.sv - directed/randomized bench for ntt_bram_stream_io with BRAM and stream reference model
module tb_ntt_bram_stream_io;
    localparam int DW = 128;
    localparam int WL = 128;
    localparam int SW = 32;
    localparam int AW = 13;
    localparam int LW = 7;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start_load = 1'b0;
    logic       start_unload = 1'b0;
    logic [7:0] cfg_lines = 8'd0;
    logic       busy, done, err_len;

    int checks = 0;
    int errors = 0;
    int n_reads = 0;
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    logic [DW-1:0] mem     [WL];
    logic [DW-1:0] exp_mem [WL];

    ntt_bram_stream_io_if #(.DW(DW), .SW(SW), .AW(AW)) io ();

    ntt_bram_stream_io #(.DW(DW), .WL(WL), .SW(SW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .start_load(start_load), .start_unload(start_unload), .cfg_lines(cfg_lines),
        .busy(busy), .done(done), .err_len(err_len),
        .io(io)
    );

    always #5 CLK = ~CLK;

    // Registered-address BRAM: Do is valid the cycle after EN/A are presented.
    always @(posedge CLK) begin
        if (io.bram_EN) begin
            if (io.bram_WE == 4'hF) begin
                mem[io.bram_A[LW+1:2]] <= io.bram_Di;
                wr_a.push_back(io.bram_A);
                wr_d.push_back(io.bram_Di);
            end else if (io.bram_WE == 4'h0) begin
                n_reads++;
            end
            io.bram_Do <= mem[io.bram_A[LW+1:2]];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            if (done === 1'b1) got = 1'b1;
            else @(negedge CLK);
        end
        chk({tag, ".done"}, got, 1'b1);
    endtask

    task automatic run_load(input string tag, input int cfg, input int tlast_at,
                            input bit seq, input bit rnd, input bit both);
        int n, consumed, lines, wbase, rbase, idx, cyc;
        bit hs;
        logic [SW-1:0] w [$];
        logic [DW-1:0] lv;
        n        = (cfg == 0 || cfg > WL) ? WL : cfg;
        consumed = (tlast_at > 0 && tlast_at < n * 4) ? tlast_at : n * 4;
        lines    = (consumed + 3) / 4;
        for (int i = 0; i < consumed; i++) w.push_back(seq ? SW'(i + 1) : SW'($urandom));
        wbase = wr_a.size();
        rbase = n_reads;
        cfg_lines    = 8'(cfg);
        start_load   = 1'b1;
        start_unload = both;
        @(negedge CLK);
        start_load   = 1'b0;
        start_unload = 1'b0;
        if (both) chk({tag, ".mode"}, {busy, io.ss_tready}, 2'b11);
        idx = 0;
        cyc = 0;
        while (idx < consumed && cyc < 4000) begin
            io.ss_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            io.ss_tdata  = w[idx];
            io.ss_tlast  = (idx + 1 == tlast_at);
            start_unload = both && (cyc == 2);
            hs = io.ss_tvalid && io.ss_tready;
            @(negedge CLK);
            cyc++;
            if (hs) idx++;
        end
        io.ss_tvalid = 1'b0;
        io.ss_tlast  = 1'b0;
        start_unload = 1'b0;
        chk({tag, ".words"}, idx, consumed);
        wait_done(tag);
        chk({tag, ".err"}, err_len, (tlast_at != n * 4));
        @(negedge CLK);
        chk({tag, ".idle"}, busy, 1'b0);
        chk({tag, ".nwr"}, wr_a.size() - wbase, lines);
        chk({tag, ".nrd"}, n_reads - rbase, 0);
        for (int i = 0; i < lines; i++) begin
            lv = '0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < consumed) lv[j*SW +: SW] = w[4 * i + j];
            exp_mem[i] = lv;
            if (wbase + i < wr_a.size()) begin
                chk($sformatf("%s.a%0d", tag, i), wr_a[wbase + i], i * 4);
                chk($sformatf("%s.d%0d", tag, i), wr_d[wbase + i], lv);
            end
        end
    endtask

    task automatic run_unload(input string tag, input int cfg, input bit toggle, input int span_exp);
        int n, nw, idx, cyc, first, last, rbase, tl_bad, hold_bad;
        bit held;
        logic [SW-1:0] hd, ew;
        logic hl;
        logic [DW-1:0] el;
        n = (cfg == 0 || cfg > WL) ? WL : cfg;
        nw = n * 4;
        rbase = n_reads;
        cfg_lines    = 8'(cfg);
        start_unload = 1'b1;
        @(negedge CLK);
        start_unload = 1'b0;
        idx = 0; cyc = 0; first = -1; last = -1; tl_bad = 0; hold_bad = 0; held = 1'b0;
        hd = '0; hl = 1'b0;
        while (idx < nw && cyc < 2000) begin
            io.sm_tready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (held && (io.sm_tvalid !== 1'b1 || io.sm_tdata !== hd || io.sm_tlast !== hl)) hold_bad++;
            held = 1'b0;
            if (io.sm_tvalid === 1'b1) begin
                if (first < 0) first = cyc;
                if (io.sm_tready) begin
                    el = exp_mem[idx / 4];
                    ew = el[(idx % 4)*SW +: SW];
                    chk($sformatf("%s.w%0d", tag, idx), io.sm_tdata, ew);
                    if (io.sm_tlast !== (idx == nw - 1)) tl_bad++;
                    idx++;
                    last = cyc;
                end else begin
                    held = 1'b1;
                    hd   = io.sm_tdata;
                    hl   = io.sm_tlast;
                end
            end
            @(negedge CLK);
            cyc++;
        end
        io.sm_tready = 1'b0;
        chk({tag, ".words"}, idx, nw);
        chk({tag, ".tlast"}, tl_bad, 0);
        chk({tag, ".hold"}, hold_bad, 0);
        if (span_exp > 0) chk({tag, ".span"}, last - first + 1, span_exp);
        wait_done(tag);
        @(negedge CLK);
        chk({tag, ".nrd"}, n_reads - rbase, n);
        chk({tag, ".idle"}, {busy, io.bram_EN, io.bram_WE}, 6'b0);
    endtask

    initial begin
        int wbase;
        io.ss_tvalid = 1'b0;
        io.ss_tdata  = '0;
        io.ss_tlast  = 1'b0;
        io.sm_tready = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        wbase = wr_a.size();
        cfg_lines  = 8'd1;
        start_load = 1'b1;
        @(negedge CLK);
        start_load   = 1'b0;
        io.ss_tvalid = 1'b1;
        io.ss_tdata  = 32'hAAAA_0001;
        @(negedge CLK);
        io.ss_tdata  = 32'hAAAA_0002;
        @(negedge CLK);
        io.ss_tvalid = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst.ctl", {busy, done, err_len, io.ss_tready, io.sm_tvalid, io.sm_tlast,
                        io.bram_EN, io.bram_WE}, 11'b0);
        chk("rst.tdata", io.sm_tdata, 0);
        chk("rst.addr", io.bram_A, 0);
        chk("rst.di", io.bram_Di, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst.nwr", wr_a.size() - wbase, 0);
        chk("rst.busy", busy, 1'b0);

        run_load("l1", 1, 4, 1'b1, 1'b0, 1'b0);
        chk("l1.di_const", wr_d[wr_d.size() - 1], 128'h00000004_00000003_00000002_00000001);
        run_load("nolast", 1, 0, 1'b0, 1'b0, 1'b0);
        run_load("full", 0, 512, 1'b0, 1'b1, 1'b0);
        run_load("short", 2, 6, 1'b0, 1'b1, 1'b0);
        chk("short.upper", wr_d[wr_d.size() - 1][DW-1:DW/2], 0);
        run_unload("u2", 2, 1'b1, 0);
        run_load("both", 1, 4, 1'b0, 1'b0, 1'b1);
`ifdef NTT_UNLOAD_PREFETCH_EN
        run_unload("u4", 4, 1'b0, 16);
`else
        run_unload("u4", 4, 1'b0, 22);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ntt_bram_stream_io.md
Name: ntt_bram_stream_io

Overview:
- Stream adapter sitting between the 32-bit AXI-Stream coefficient path and the NTT 128-bit x 128-line coefficient BRAM.
- Load mode: packs four 32-bit words into one 128-bit line and writes it to the BRAM.
- Unload mode: reads lines back, absorbing the BRAM's one-cycle registered-address read latency, and serialises them as 32-bit stream words.
- The block is the BRAM's only master during kernel load and unload.

Parameters:
- DW, 128, BRAM line width; must equal 4*SW.
- WL, 128, BRAM depth in lines.
- SW, 32, stream word width.
- AW, 13, BRAM byte-style address width; line i is addressed as A = i<<2.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- start_load  in  1  pulse; begins load when IDLE
- start_unload  in  1  pulse; begins unload when IDLE
- cfg_lines  in  8  line count, sampled at start; 0 means WL; values >WL clamp to WL
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse when an operation completes
- err_len  out  1  sticky tlast-mismatch flag; cleared by the next accepted start
- ss_tvalid  in  1  input stream valid
- ss_tdata  in  SW  input stream data
- ss_tlast  in  1  input stream last
- ss_tready  out  1  input stream ready
- sm_tvalid  out  1  output stream valid
- sm_tdata  out  SW  output stream data
- sm_tlast  out  1  output stream last
- sm_tready  in  1  output stream ready
- bram_EN  out  1  BRAM enable
- bram_WE  out  4  BRAM write enable; 4'hF to write, 4'h0 to read
- bram_A  out  AW  BRAM address
- bram_Di  out  DW  BRAM write data
- bram_Do  in  DW  BRAM read data; valid the cycle after A is presented with EN=1

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pack/line counters 0, any in-flight line discarded.
- All BRAM-side outputs are registered.
- States: IDLE, LOAD, LWR, UREAD, UCAP, UEMIT, FIN.
- IDLE:
  - start_load -> LOAD. start_unload -> UREAD.
  - Both asserted in the same cycle: load wins.
  - Starts are ignored while busy.
- LOAD:
  - ss_tready=1. Each handshake stores ss_tdata into word slot k (bits 32k+31:32k); the first word goes to the LSBs.
  - On the 4th word, or on tlast -> LWR; unfilled slots are zero.
- LWR (one cycle):
  - bram_EN=1, WE=4'hF, A=line<<2, Di=packed line; ss_tready=0.
  - Then line++.
  - line==cfg_lines or tlast seen -> FIN; else -> LOAD.
- err_len is set in either case:
  - tlast arrives before word cfg_lines*4;
  - tlast is absent on word cfg_lines*4.
- UREAD: EN=1, WE=0, A=line<<2, for one cycle.
- UCAP: capture bram_Do into the shift register; EN=0.
- UEMIT:
  - sm_tvalid=1; sm_tdata = word slot k, LSB slot first; advance on sm_tready.
  - sm_tlast=1 only on slot 3 of line cfg_lines-1.
  - After slot 3: line++, then -> UREAD, or -> FIN when done.
  - sm_tvalid/sm_tdata hold stable while stalled.
- Throughput: one line per 6 cycles at full ready.
- FIN: done=1 for one cycle, busy=0 next cycle, -> IDLE.
- Line counter never exceeds WL-1; no address wrap-around.
- While idle: EN=0, WE=0.

Optional Feature:
- Macro: NTT_UNLOAD_PREFETCH_EN.
- Defined:
  - A second 128-bit line buffer is added.
  - The read of line+1 is issued while slot 1 of the current line is emitted.
  - Back-to-back lines stream with sm_tvalid continuously high: 4 words per 4 cycles at full ready.
  - A prefetch is never issued past line cfg_lines-1.
- Undefined: the 6-cycle-per-line sequence above; no second buffer.

Test Plan:
- Reset mid-LOAD after 2 words -> all outputs 0, no BRAM write issued; a fresh load of 1 line (words 1,2,3,4, tlast on 4) writes A=0, Di=0x00000004_00000003_00000002_00000001.
- Load cfg_lines=0, 512 words with ss_tvalid random, tlast on word 512 -> 128 writes at A=0,4,...,508; done pulse; err_len=0.
- Load cfg_lines=2, tlast on word 6 -> line1 Di upper 64 bits zero; done; err_len=1.
- Unload cfg_lines=2 after the load above, sm_tready toggling 1/0 -> 8 words in order with tlast on word 8; data held stable across stalls.
- start_load and start_unload asserted together -> load performed; start_unload during busy ignored.
- With NTT_UNLOAD_PREFETCH_EN and sm_tready=1, unload 4 lines -> 16 consecutive valid cycles, no bubble.
